mealy_1010_seq_generator: RTL and testbench

MEALY_1010_SEQ_GENERATOR -- requirements
Module: mealy_1010_seq_generator

---
 rtl/mealy_1010_seq_generator.sv | 131 +++++++++++++
 tb/tb_mealy_1010_seq_generator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_1010_seq_generator.sv
// Serial pattern burst generator: sends PATTERN (MSB first) count times, then pulses done.
// Define SEQGEN_GAP_EN to insert a one-cycle idle gap between consecutive repetitions.
module mealy_1010_seq_generator #(
    parameter logic [31:0] PATTERN = 32'b1010,
    parameter int          PAT_LEN = 4,
    parameter int          CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start
    // SEND  | driving pattern bits
    // GAP   | one idle cycle between repetitions (SEQGEN_GAP_EN only)
    // FIN   | done pulse, back to IDLE next edge
    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    // idx only ever holds PAT_LEN-2 down to 0
    localparam int IDX_W = (PAT_LEN > 2) ? $clog2(PAT_LEN - 1) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'((PAT_LEN > 1) ? PAT_LEN - 2 : 0);
    localparam logic FIRST_IS_LAST = (PAT_LEN == 1);
    localparam logic MSB_BIT = PATTERN[PAT_LEN-1];

    state_t           state, state_nx;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             last, last_nx;
    logic             out_nx, out_valid_nx, busy_nx, done_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rep_cnt   <= '0;
            idx       <= '0;
            last      <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            rep_cnt   <= rep_cnt_nx;
            idx       <= idx_nx;
            last      <= last_nx;
            out       <= out_nx;
            out_valid <= out_valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    // last marks that the bit currently on out is PATTERN[0]
    always_comb begin
        state_nx     = state;
        rep_cnt_nx   = rep_cnt;
        idx_nx       = idx;
        last_nx      = last;
        out_nx       = 1'b0;
        out_valid_nx = 1'b0;
        busy_nx      = busy;
        done_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        rep_cnt_nx   = count;
                        out_nx       = MSB_BIT;
                        out_valid_nx = 1'b1;
                        busy_nx      = 1'b1;
                        idx_nx       = IDX_TOP;
                        last_nx      = FIRST_IS_LAST;
                        state_nx     = SEND;
                    end else begin
                        // empty burst: busy would drop on the very edge it rises, so it never shows
                        state_nx = FIN;
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                    end
                end
            end
            SEND: begin
                if (!last) begin
                    out_nx       = PATTERN[idx];
                    out_valid_nx = 1'b1;
                    last_nx      = (idx == '0);
                    idx_nx       = idx - IDX_W'(1);
                end else begin
                    rep_cnt_nx = rep_cnt - CNT_W'(1);
                    if (rep_cnt == CNT_W'(1)) begin
                        state_nx = FIN;
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                    end else begin
`ifdef SEQGEN_GAP_EN
                        state_nx = GAP;
`else
                        out_nx       = MSB_BIT;
                        out_valid_nx = 1'b1;
                        idx_nx       = IDX_TOP;
                        last_nx      = FIRST_IS_LAST;
`endif
                    end
                end
            end
`ifdef SEQGEN_GAP_EN
            GAP: begin
                out_nx       = MSB_BIT;
                out_valid_nx = 1'b1;
                idx_nx       = IDX_TOP;
                last_nx      = FIRST_IS_LAST;
                state_nx     = SEND;
            end
`endif
            FIN: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mealy_1010_seq_generator.sv
// Scoreboard bench for mealy_1010_seq_generator: a stream model predicts every bit and done pulse with its cycle stamp.
module tb_mealy_1010_seq_generator;

    localparam int L  = 4;
    localparam int CW = 4;
`ifdef SEQGEN_GAP_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif

    typedef struct {
        bit is_done;
        bit val;
        int stamp;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] count;
    logic          out, out_valid, busy, done;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   end_req = 1'b0;
    bit   end_ack = 1'b0;
    ev_t  exp_q[$];
    logic [3:0] pat = 4'b1010;

    mealy_1010_seq_generator #(
        .PATTERN(32'b1010),
        .PAT_LEN(L),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count    (count),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected stream for a burst accepted at edge n: c copies of the pattern, optional gaps, then done.
    task automatic push_burst(input int n, input int c, output int d);
        ev_t e;
        for (int r = 0; r < c; r++) begin
            for (int k = 0; k < L; k++) begin
                e.is_done = 1'b0;
                e.val     = pat[L-1-k];
                e.stamp   = n + r * (L + G) + k;
                exp_q.push_back(e);
            end
        end
        d = (c == 0) ? n : n + c * L + (c - 1) * G;
        e.is_done = 1'b1;
        e.val     = 1'b0;
        e.stamp   = d;
        exp_q.push_back(e);
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge after the FIN->IDLE edge.
    task automatic run_burst(input int c, input bit repulse);
        int n, d, e;
        start = 1'b1;
        count = CW'(c);
        n = cyc + 1;
        push_burst(n, c, d);
        @(negedge clk);
        start = 1'b0;
        count = CW'($urandom);
        if (repulse) begin
            e = $urandom_range(d + 1, n + 1);
            while (cyc < e - 1) @(negedge clk);
            start = 1'b1;
            count = CW'(5);
            @(negedge clk);
            start = 1'b0;
        end
        while (cyc < d + 1) @(negedge clk);
    endtask

    // start held high across the end of a burst relaunches it once the FSM is back in IDLE.
    task automatic hold_two(input int c);
        int n, d, n2, d2;
        start = 1'b1;
        count = CW'(c);
        n = cyc + 1;
        push_burst(n, c, d);
        n2 = d + 2;
        push_burst(n2, c, d2);
        while (cyc < n2) @(negedge clk);
        start = 1'b0;
        while (cyc < d2 + 1) @(negedge clk);
    endtask

    task automatic reset_mid();
        int n, d;
        start = 1'b1;
        count = CW'(2);
        n = cyc + 1;
        push_burst(n, 2, d);
        @(negedge clk);
        start = 1'b0;
        while (cyc < n + 2) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: sole owner of the pass/fail counters.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                tests++;
                if (out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_outputs: got out=%b out_valid=%b busy=%b done=%b, required all 0",
                             out, out_valid, busy, done);
                end
            end else begin
                while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                    e = exp_q.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missed_event: done=%0d bit=%0d expected at cycle %0d, not seen by cycle %0d",
                             e.is_done, e.val, e.stamp, cyc);
                end
                if (out_valid === 1'b1) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_bit: got out=%b at cycle %0d, required no output", out, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_done || e.val !== out || e.stamp != cyc) begin
                            fails++;
                            $display("FAIL bit: got out=%b at cycle %0d, required %s %b at cycle %0d",
                                     out, cyc, e.is_done ? "done" : "bit", e.val, e.stamp);
                        end
                    end
                    tests++;
                    if (busy !== 1'b1) begin
                        fails++;
                        $display("FAIL busy_with_bit: got busy=%b at cycle %0d, required 1", busy, cyc);
                    end
                end else begin
                    tests++;
                    if (out !== 1'b0) begin
                        fails++;
                        $display("FAIL out_zero_when_invalid: got out=%b at cycle %0d, required 0", out, cyc);
                    end
                end
                if (done === 1'b1) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_done: got done=1 at cycle %0d, required 0", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.is_done || e.stamp != cyc) begin
                            fails++;
                            $display("FAIL done: got done=1 at cycle %0d, required %s at cycle %0d",
                                     cyc, e.is_done ? "done" : "bit", e.stamp);
                        end
                    end
                    tests++;
                    if (busy !== 1'b0) begin
                        fails++;
                        $display("FAIL busy_with_done: got busy=%b at cycle %0d, required 0", busy, cyc);
                    end
                end
                if (end_req && !end_ack) begin
                    tests++;
                    if (exp_q.size() != 0) begin
                        fails++;
                        $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
                    end
                    end_ack = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_burst(2, 1'b0);
        run_burst(0, 1'b0);
        run_burst(2, 1'b1);
        run_burst(15, 1'b0);
        hold_two(3);
        reset_mid();
        run_burst(2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            run_burst($urandom_range(15, 0), 1'($urandom_range(1, 0)));
        end
        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_ack; i++) @(posedge clk);
        if (!end_ack) $display("FAIL end_handshake: monitor did not acknowledge, required ack");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
